// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Package     : rv32i_types
// Description : Shared types for the physical-memory arbiter (FSM state,
//               request source) and line geometry.
// Revision    : 1.0
// ============================================================================
package rv32i_types;

    localparam int LINE_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } pmem_arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } arb_src_t;

endpackage
`default_nettype wire

// File: rtl/arb_perf_ctr.sv
`default_nettype none
// ============================================================================
// Module      : arb_perf_ctr
// Description : Saturating event counter; advances once per cycle with inc
//               and holds at all-ones.
// Revision    : 1.0
// ============================================================================
module arb_perf_ctr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin : p_next
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_reg
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pmem_arbiter
// Description : Round-robin arbiter sharing one line-granular memory port
//               between the icache (fills) and dcache (fills/writebacks).
//               Optional performance counters: define PMEM_ARB_PERF_EN.
// Revision    : 1.0
// ============================================================================
module pmem_arbiter
    import rv32i_types::*;
#(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [s_addr-1:0] i_addr,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_addr-1:0] d_addr,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_addr-1:0] pmem_addr,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp,
    input  logic              pmem_error
`ifdef PMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_wait_cycles
`endif
);

    localparam int TAG_W = s_addr - LINE_OFFSET_BITS;

    pmem_arb_state_t   state_q, state_d;
    arb_src_t          last_grant_q, last_grant_d;
    logic [TAG_W-1:0]  addr_q, addr_d;
    logic              write_q, write_d;
    logic [s_line-1:0] wdata_q, wdata_d;
    logic [s_line-1:0] i_rdata_q, i_rdata_d;
    logic [s_line-1:0] d_rdata_q, d_rdata_d;

    logic i_req, d_req;
    logic grant_i, grant_d;
    logic xfer_done, i_done, d_done;
    logic unused_addr_bits;

    assign i_req     = i_read;
    assign d_req     = d_read | d_write;
    assign xfer_done = pmem_resp | pmem_error;
    assign i_done    = (state_q == GNT_I) & xfer_done;
    assign d_done    = (state_q == GNT_D) & xfer_done;

    // Line offset bits never reach memory; only the line tag is latched.
    assign unused_addr_bits = ^{i_addr[LINE_OFFSET_BITS-1:0], d_addr[LINE_OFFSET_BITS-1:0]};

    // On contention the side that was not served last wins.
    always_comb begin : p_grant
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (i_req && d_req) begin
                grant_i = (last_grant_q == DCACHE);
                grant_d = (last_grant_q == ICACHE);
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : p_next_state
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = GNT_I;
                end else if (grant_d) begin
                    state_d = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (xfer_done) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured at grant so memory never sees live inputs.
    always_comb begin : p_datapath
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        if (grant_i) begin
            last_grant_d = ICACHE;
            addr_d       = i_addr[s_addr-1:LINE_OFFSET_BITS];
            write_d      = 1'b0;
        end else if (grant_d) begin
            last_grant_d = DCACHE;
            addr_d       = d_addr[s_addr-1:LINE_OFFSET_BITS];
            write_d      = d_write;
            wdata_d      = d_wdata;
        end
        if (i_done) begin
            i_rdata_d = pmem_rdata;
        end
        if (d_done) begin
            d_rdata_d = pmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_data_reg
        if (!rst_n) begin
            last_grant_q <= ICACHE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin : p_outputs
        pmem_read  = (state_q == GNT_I) | ((state_q == GNT_D) & ~write_q);
        pmem_write = (state_q == GNT_D) & write_q;
        pmem_addr  = {addr_q, {LINE_OFFSET_BITS{1'b0}}};
        pmem_wdata = wdata_q;
        i_resp     = i_done;
        d_resp     = d_done;
        i_rdata    = i_done ? pmem_rdata : i_rdata_q;
        d_rdata    = d_done ? pmem_rdata : d_rdata_q;
    end

`ifdef PMEM_ARB_PERF_EN
    logic wait_i, wait_d;

    // A side is not waiting while it is granted or in its own DONE bubble.
    assign wait_i = i_req && (state_q != GNT_I)
                    && !((state_q == DONE) && (last_grant_q == ICACHE));
    assign wait_d = d_req && (state_q != GNT_D)
                    && !((state_q == DONE) && (last_grant_q == DCACHE));

    arb_perf_ctr #(.WIDTH(32)) u_ctr_i_grants (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_i),
        .count (perf_i_grants)
    );

    arb_perf_ctr #(.WIDTH(32)) u_ctr_d_grants (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_d),
        .count (perf_d_grants)
    );

    arb_perf_ctr #(.WIDTH(32)) u_ctr_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_i | wait_d),
        .count (perf_wait_cycles)
    );
`endif

endmodule
`default_nettype wire
